// File: rtl/ppm_encoder.sv
// 8-channel RC PPM encoder with per-frame shadowed channel widths.
// Define PPM_INVERT_EN to invert the ppm_output polarity.
module ppm_encoder #(
    parameter int TICKS_PER_US = 12,
    parameter int FRAME_US     = 22500,
    parameter int SEP_US       = 300,
    parameter int MIN_US       = 1000,
    parameter int MAX_US       = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ch_wr,
    input  logic [2:0]  ch_addr,
    input  logic [11:0] ch_data,
    output logic        ppm_output,
    output logic        frame_start
);

    localparam int PW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
`ifdef PPM_INVERT_EN
    localparam logic IDLE = 1'b1;
`else
    localparam logic IDLE = 1'b0;
`endif
    localparam logic [11:0] DEF_THR = 12'(MIN_US);
    localparam logic [11:0] DEF_MID = 12'((MIN_US + MAX_US) / 2);

    typedef enum logic [1:0] {
        CH_SEP,
        CH_GAP,
        SYNC_SEP,
        SYNC
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     ch_q, ch_d;
    logic [PW-1:0]  pre_q, pre_d;
    logic [14:0]    cnt_q, cnt_d;
    logic           init_q, init_d;
    logic           ppm_q, ppm_d;
    logic           fs_q, fs_d;
    logic [11:0]    hold_q [8];
    logic [11:0]    hold_d [8];
    logic [11:0]    shad_q [8];
    logic [11:0]    shad_d [8];
    logic [14:0]    sum;
    logic [14:0]    dur;
    logic           tick;
    logic           done;
    logic           load;

    function automatic logic [11:0] clamp(input logic [11:0] d);
        if (d < 12'(MIN_US)) return 12'(MIN_US);
        if (d > 12'(MAX_US)) return 12'(MAX_US);
        return d;
    endfunction

    always_comb begin
        sum = '0;
        for (int k = 0; k < 8; k++) sum = sum + 15'(shad_q[k]);
        unique case (state_q)
            CH_GAP:  dur = 15'(shad_q[ch_q]) - 15'(SEP_US);
            SYNC:    dur = 15'(FRAME_US) - sum - 15'(SEP_US);
            default: dur = 15'(SEP_US);
        endcase
        tick = (pre_q == PW'(TICKS_PER_US - 1));
        done = tick && (cnt_q == dur - 15'd1);
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        pre_d   = tick ? '0 : pre_q + PW'(1);
        cnt_d   = done ? '0 : (tick ? cnt_q + 15'd1 : cnt_q);
        init_d  = 1'b0;
        fs_d    = 1'b0;
        load    = 1'b0;
        hold_d  = hold_q;
        shad_d  = shad_q;
        if (ch_wr) hold_d[ch_addr] = clamp(ch_data);
        // first edge out of reset enters channel 0's separator directly
        if (init_q) begin
            load  = 1'b1;
            pre_d = '0;
            cnt_d = '0;
        end else if (done) begin
            unique case (state_q)
                CH_SEP: state_d = CH_GAP;
                CH_GAP: begin
                    if (ch_q == 3'd7) begin
                        state_d = SYNC_SEP;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        state_d = CH_SEP;
                    end
                end
                SYNC_SEP: state_d = SYNC;
                default: begin
                    ch_d    = 3'd0;
                    state_d = CH_SEP;
                    load    = 1'b1;
                end
            endcase
        end
        if (load) begin
            shad_d = hold_q;
            fs_d   = 1'b1;
        end
        ppm_d = (state_d == CH_SEP || state_d == SYNC_SEP) ? ~IDLE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CH_SEP;
            ch_q    <= '0;
            pre_q   <= '0;
            cnt_q   <= '0;
            init_q  <= 1'b1;
            ppm_q   <= IDLE;
            fs_q    <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                hold_q[k] <= (k == 2) ? DEF_THR : DEF_MID;
                shad_q[k] <= (k == 2) ? DEF_THR : DEF_MID;
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            ppm_q   <= ppm_d;
            fs_q    <= fs_d;
            hold_q  <= hold_d;
            shad_q  <= shad_d;
        end
    end

    assign ppm_output  = ppm_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ppm_encoder.sv
// Bench for ppm_encoder on a scaled timebase (2 clk/us, 2250 us frame).
// Pulse runs are compared against widths computed from channel values.
module tb_ppm_encoder;

    localparam int T  = 2;
    localparam int FR = 2250;
    localparam int SP = 30;
    localparam int MN = 100;
    localparam int MX = 200;
    localparam int FRAME_CYC = FR * T;
`ifdef PPM_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ch_wr = 1'b0;
    logic [2:0]  ch_addr = '0;
    logic [11:0] ch_data = '0;
    logic        ppm_output;
    logic        frame_start;

    int pass_cnt = 0;
    int total = 0;
    int hold_m [8];
    int sh_m [8];
    int cur_m [8];
    int runs [$];
    int exp_q [$];
    int frame_len;

    ppm_encoder #(
        .TICKS_PER_US(T),
        .FRAME_US(FR),
        .SEP_US(SP),
        .MIN_US(MN),
        .MAX_US(MX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch_wr(ch_wr),
        .ch_addr(ch_addr),
        .ch_data(ch_data),
        .ppm_output(ppm_output),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic int clampv(int d);
        return (d < MN) ? MN : ((d > MX) ? MX : d);
    endfunction

    function automatic bit act();
        return ppm_output ^ INV;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 8; k++) hold_m[k] = (k == 2) ? MN : (MN + MX) / 2;
        sh_m = hold_m;
    endfunction

    function automatic void build_exp();
        int s;
        s = 0;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(SP * T);
            exp_q.push_back((cur_m[k] - SP) * T);
            s += cur_m[k];
        end
        exp_q.push_back(SP * T);
        exp_q.push_back((FR - s - SP) * T);
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge clk);
        ch_wr = 1'b1;
        ch_addr = 3'(a);
        ch_data = 12'(d);
        @(negedge clk);
        ch_wr = 1'b0;
        hold_m[a] = clampv(d);
    endtask

    // Starts on the negedge where frame_start is seen; ends on the next one.
    task automatic capture_frame(output bit ok);
        int len;
        int n;
        bit lvl;
        runs.delete();
        cur_m = sh_m;
        lvl = act();
        len = 1;
        n = 1;
        ok = 1'b0;
        frame_len = 0;
        while (n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
            if (frame_start) begin
                runs.push_back(len);
                frame_len = n - 1;
                sh_m = hold_m;
                ok = 1'b1;
                break;
            end
            if (act() !== lvl) begin
                runs.push_back(len);
                lvl = act();
                len = 1;
            end else begin
                len++;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        repeat (3) @(negedge clk);
        total++;
        if (ppm_output !== INV)
            $display("FAIL reset_ppm: got %b want %b", ppm_output, INV);
        else pass_cnt++;
        total++;
        if (frame_start !== 1'b0)
            $display("FAIL reset_fs: got %b want 0", frame_start);
        else pass_cnt++;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (frame_start !== 1'b1 || act() !== 1'b1)
            $display("FAIL first_edge: got fs=%b act=%b want 1 1", frame_start, act());
        else pass_cnt++;
        capture_frame(ok);
        build_exp();
        total++;
        if (!ok || runs.size() != exp_q.size()) begin
            $display("FAIL default_runs: got %0d want %0d", runs.size(), exp_q.size());
        end else begin
            pass_cnt++;
            foreach (exp_q[k]) begin
                total++;
                if (runs[k] !== exp_q[k])
                    $display("FAIL default_run%0d: got %0d want %0d", k, runs[k], exp_q[k]);
                else pass_cnt++;
            end
        end
        total++;
        if (frame_len !== FRAME_CYC)
            $display("FAIL default_period: got %0d want %0d", frame_len, FRAME_CYC);
        else pass_cnt++;
    endtask

    task automatic test_clamp();
        bit ok;
        int lo;
        int hi;
        lo = $urandom_range(0, MN - 1);
        hi = $urandom_range(MX + 1, 4095);
        fork
            capture_frame(ok);
            begin
                wr(0, lo);
                wr(1, hi);
                wr(5, $urandom_range(MN, MX));
            end
        join
        for (int f = 0; f < 2; f++) begin
            if (f == 1) capture_frame(ok);
            build_exp();
            total++;
            if (!ok || runs.size() != exp_q.size()) begin
                $display("FAIL clamp_f%0d_runs: got %0d want %0d", f, runs.size(), exp_q.size());
            end else begin
                pass_cnt++;
                foreach (exp_q[k]) begin
                    total++;
                    if (runs[k] !== exp_q[k])
                        $display("FAIL clamp_f%0d_run%0d: got %0d want %0d", f, k, runs[k], exp_q[k]);
                    else pass_cnt++;
                end
            end
        end
        total++;
        if (ok && runs.size() > 3 && (runs[0] + runs[1] !== MN * T || runs[2] + runs[3] !== MX * T))
            $display("FAIL clamp_slots: got %0d %0d want %0d %0d",
                     runs[0] + runs[1], runs[2] + runs[3], MN * T, MX * T);
        else if (!ok || runs.size() <= 3)
            $display("FAIL clamp_slots: got no frame want %0d %0d", MN * T, MX * T);
        else pass_cnt++;
    endtask

    task automatic test_midframe();
        bit ok;
        int v;
        int dly;
        v = $urandom_range(MN + 1, MX);
        dly = $urandom_range(200, 2500);
        fork
            capture_frame(ok);
            begin
                repeat (dly) @(negedge clk);
                wr(3, v);
            end
        join
        for (int f = 0; f < 2; f++) begin
            if (f == 1) capture_frame(ok);
            build_exp();
            total++;
            if (!ok || runs.size() != exp_q.size()) begin
                $display("FAIL mid_f%0d_runs: got %0d want %0d", f, runs.size(), exp_q.size());
            end else begin
                pass_cnt++;
                for (int k = 6; k < 8; k++) begin
                    total++;
                    if (runs[k] !== exp_q[k])
                        $display("FAIL mid_f%0d_run%0d: got %0d want %0d", f, k, runs[k], exp_q[k]);
                    else pass_cnt++;
                end
                total++;
                if (runs[17] !== exp_q[17])
                    $display("FAIL mid_f%0d_sync: got %0d want %0d", f, runs[17], exp_q[17]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_all_max();
        bit ok;
        fork
            capture_frame(ok);
            for (int c = 0; c < 8; c++) wr(c, (c % 2) ? MX : $urandom_range(MX, 4095));
        join
        capture_frame(ok);
        build_exp();
        total++;
        if (!ok || runs.size() != exp_q.size()) begin
            $display("FAIL max_runs: got %0d want %0d", runs.size(), exp_q.size());
        end else begin
            pass_cnt++;
            foreach (exp_q[k]) begin
                total++;
                if (runs[k] !== exp_q[k])
                    $display("FAIL max_run%0d: got %0d want %0d", k, runs[k], exp_q[k]);
                else pass_cnt++;
            end
            total++;
            if (runs[17] !== (FR - 8 * MX - SP) * T)
                $display("FAIL max_sync: got %0d want %0d", runs[17], (FR - 8 * MX - SP) * T);
            else pass_cnt++;
        end
        total++;
        if (frame_len !== FRAME_CYC)
            $display("FAIL max_period: got %0d want %0d", frame_len, FRAME_CYC);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int off;
        off = (sh_m[0] + sh_m[1] + sh_m[2] + sh_m[3]) * T + $urandom_range(5, 100);
        repeat (off) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ppm_output !== INV || frame_start !== 1'b0)
            $display("FAIL midrst_out: got ppm=%b fs=%b want %b 0", ppm_output, frame_start, INV);
        else pass_cnt++;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (frame_start !== 1'b1 || act() !== 1'b1)
            $display("FAIL midrst_restart: got fs=%b act=%b want 1 1", frame_start, act());
        else pass_cnt++;
        capture_frame(ok);
        build_exp();
        total++;
        if (!ok || runs.size() != exp_q.size()) begin
            $display("FAIL midrst_runs: got %0d want %0d", runs.size(), exp_q.size());
        end else begin
            pass_cnt++;
            foreach (exp_q[k]) begin
                total++;
                if (runs[k] !== exp_q[k])
                    $display("FAIL midrst_run%0d: got %0d want %0d", k, runs[k], exp_q[k]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_midframe();
        test_all_max();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
